// File: rtl/envelope_length_unit.sv
// Envelope generator and length counter for one NES APU pulse/noise channel.
// Optional macro LENGTH_RELOAD_GUARD_EN: a length clock that coincides with a length write decrements instead of reloading.
module envelope_length_unit #(
    parameter int LENGTH_WIDTH = 8,
    parameter int ENV_WIDTH    = 4
) (
    input  logic                 iClk,
    input  logic                 iReset,
    input  logic [7:0]           iData,
    input  logic                 iWrite_ctrl,
    input  logic                 iWrite_length,
    input  logic                 iEnable,
    input  logic                 iEnvelope_clk,
    input  logic                 iLength_clk,
    output logic [ENV_WIDTH-1:0] oVolume,
    output logic                 oLength_nonzero
);

    localparam logic [ENV_WIDTH-1:0]    ENV_MAX = '1;
    localparam logic [ENV_WIDTH-1:0]    ENV_ONE = ENV_WIDTH'(1);
    localparam logic [LENGTH_WIDTH-1:0] LEN_ONE = LENGTH_WIDTH'(1);

    logic                    halt_q, halt_d;
    logic                    const_vol_q, const_vol_d;
    logic [ENV_WIDTH-1:0]    vol_period_q, vol_period_d;
    logic                    start_q, start_d;
    logic [ENV_WIDTH-1:0]    decay_q, decay_d;
    logic [ENV_WIDTH-1:0]    divider_q, divider_d;
    logic [LENGTH_WIDTH-1:0] length_q, length_d;
    logic [ENV_WIDTH-1:0]    volume_q, volume_d;
    logic                    length_nonzero_q, length_nonzero_d;

    logic                    length_dec_ok;
    logic [LENGTH_WIDTH-1:0] length_load;

    function automatic logic [7:0] len_table(input logic [4:0] idx);
        case (idx)
            5'd0:  len_table = 8'd10;   5'd1:  len_table = 8'd254;
            5'd2:  len_table = 8'd20;   5'd3:  len_table = 8'd2;
            5'd4:  len_table = 8'd40;   5'd5:  len_table = 8'd4;
            5'd6:  len_table = 8'd80;   5'd7:  len_table = 8'd6;
            5'd8:  len_table = 8'd160;  5'd9:  len_table = 8'd8;
            5'd10: len_table = 8'd60;   5'd11: len_table = 8'd10;
            5'd12: len_table = 8'd14;   5'd13: len_table = 8'd12;
            5'd14: len_table = 8'd26;   5'd15: len_table = 8'd14;
            5'd16: len_table = 8'd12;   5'd17: len_table = 8'd16;
            5'd18: len_table = 8'd24;   5'd19: len_table = 8'd18;
            5'd20: len_table = 8'd48;   5'd21: len_table = 8'd20;
            5'd22: len_table = 8'd96;   5'd23: len_table = 8'd22;
            5'd24: len_table = 8'd192;  5'd25: len_table = 8'd24;
            5'd26: len_table = 8'd72;   5'd27: len_table = 8'd26;
            5'd28: len_table = 8'd16;   5'd29: len_table = 8'd28;
            5'd30: len_table = 8'd32;   default: len_table = 8'd30;
        endcase
    endfunction

    assign length_dec_ok = iLength_clk && !halt_q && (length_q != '0);
    assign length_load   = LENGTH_WIDTH'(len_table(iData[7:3]));

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        halt_d           = halt_q;
        const_vol_d      = const_vol_q;
        vol_period_d     = vol_period_q;
        start_d          = start_q;
        decay_d          = decay_q;
        divider_d        = divider_q;
        length_d         = length_q;
        volume_d         = volume_q;
        length_nonzero_d = length_nonzero_q;

        if (iWrite_ctrl) begin
            halt_d       = iData[5];
            const_vol_d  = iData[4];
            vol_period_d = ENV_WIDTH'(iData[3:0]);
        end

        // The envelope step sees the pre-write start flag; a length write then re-arms it.
        if (iEnvelope_clk) begin
            if (start_q) begin
                start_d   = 1'b0;
                decay_d   = ENV_MAX;
                divider_d = vol_period_q;
            end else if (divider_q == '0) begin
                divider_d = vol_period_q;
                if (decay_q != '0)
                    decay_d = decay_q - ENV_ONE;
                else if (halt_q)
                    decay_d = ENV_MAX;
            end else begin
                divider_d = divider_q - ENV_ONE;
            end
        end
        if (iWrite_length)
            start_d = 1'b1;

        if (!iEnable) begin
            length_d = '0;
        end else if (iWrite_length) begin
`ifdef LENGTH_RELOAD_GUARD_EN
            length_d = length_dec_ok ? (length_q - LEN_ONE) : length_load;
`else
            length_d = length_load;
`endif
        end else if (length_dec_ok) begin
            length_d = length_q - LEN_ONE;
        end

        volume_d         = (length_q == '0) ? '0 : (const_vol_q ? vol_period_q : decay_q);
        length_nonzero_d = (length_q != '0);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            halt_q           <= 1'b0;
            const_vol_q      <= 1'b0;
            vol_period_q     <= '0;
            start_q          <= 1'b0;
            decay_q          <= '0;
            divider_q        <= '0;
            length_q         <= '0;
            volume_q         <= '0;
            length_nonzero_q <= 1'b0;
        end else begin
            halt_q           <= halt_d;
            const_vol_q      <= const_vol_d;
            vol_period_q     <= vol_period_d;
            start_q          <= start_d;
            decay_q          <= decay_d;
            divider_q        <= divider_d;
            length_q         <= length_d;
            volume_q         <= volume_d;
            length_nonzero_q <= length_nonzero_d;
        end
    end

    assign oVolume         = volume_q;
    assign oLength_nonzero = length_nonzero_q;

endmodule

// File: tb/tb_envelope_length_unit.sv
// Directed and randomized bench for envelope_length_unit against an integer reference model.
module tb_envelope_length_unit;

    logic       iClk = 1'b0;
    logic       iReset = 1'b1;
    logic [7:0] iData = 8'h00;
    logic       iWrite_ctrl = 1'b0;
    logic       iWrite_length = 1'b0;
    logic       iEnable = 1'b0;
    logic       iEnvelope_clk = 1'b0;
    logic       iLength_clk = 1'b0;
    logic [3:0] oVolume;
    logic       oLength_nonzero;

    envelope_length_unit dut (
        .iClk            (iClk),
        .iReset          (iReset),
        .iData           (iData),
        .iWrite_ctrl     (iWrite_ctrl),
        .iWrite_length   (iWrite_length),
        .iEnable         (iEnable),
        .iEnvelope_clk   (iEnvelope_clk),
        .iLength_clk     (iLength_clk),
        .oVolume         (oVolume),
        .oLength_nonzero (oLength_nonzero)
    );

    always #5 iClk = ~iClk;

    int n_checks = 0;
    int n_pass   = 0;

    int len_tab[32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                        12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

    // Reference model: channel state as plain integers.
    int m_halt, m_cvol, m_period, m_start, m_decay, m_div, m_len;
    int exp_vol, exp_nz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_clear();
        m_halt = 0; m_cvol = 0; m_period = 0; m_start = 0;
        m_decay = 0; m_div = 0; m_len = 0; exp_vol = 0; exp_nz = 0;
    endtask

    task automatic model_edge();
        int n_start, n_decay, n_div, n_len;
        bit dec_ok;
        exp_vol = (m_len == 0) ? 0 : (m_cvol ? m_period : m_decay);
        exp_nz  = (m_len != 0);
        n_start = m_start; n_decay = m_decay; n_div = m_div; n_len = m_len;
        if (iEnvelope_clk) begin
            if (m_start) begin
                n_start = 0; n_decay = 15; n_div = m_period;
            end else if (m_div == 0) begin
                n_div = m_period;
                if (m_decay > 0)  n_decay = m_decay - 1;
                else if (m_halt)  n_decay = 15;
            end else begin
                n_div = m_div - 1;
            end
        end
        if (iWrite_length) n_start = 1;
        dec_ok = iLength_clk && (m_halt == 0) && (m_len > 0);
        if (!iEnable) n_len = 0;
        else if (iWrite_length) begin
`ifdef LENGTH_RELOAD_GUARD_EN
            n_len = dec_ok ? m_len - 1 : len_tab[iData[7:3]];
`else
            n_len = len_tab[iData[7:3]];
`endif
        end else if (dec_ok) n_len = m_len - 1;
        if (iWrite_ctrl) begin
            m_halt = iData[5]; m_cvol = iData[4]; m_period = iData[3:0];
        end
        m_start = n_start; m_decay = n_decay; m_div = n_div; m_len = n_len;
    endtask

    // One clock edge: advance the model, then compare registered outputs 1 ns later.
    task automatic tick();
        @(posedge iClk);
        if (iReset) model_clear();
        else model_edge();
        #1;
        check("tick_volume", oVolume, exp_vol);
        check("tick_len_nz", oLength_nonzero, exp_nz);
    endtask

    task automatic write_ctrl(input logic [7:0] d);
        iData = d; iWrite_ctrl = 1'b1; tick(); iWrite_ctrl = 1'b0;
    endtask

    task automatic write_length(input logic [7:0] d);
        iData = d; iWrite_length = 1'b1; tick(); iWrite_length = 1'b0;
    endtask

    task automatic env_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            iEnvelope_clk = 1'b1; tick(); iEnvelope_clk = 1'b0;
        end
        tick();
    endtask

    task automatic len_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            iLength_clk = 1'b1; tick(); iLength_clk = 1'b0;
        end
        tick();
    endtask

    initial begin
        model_clear();
        tick(); tick();
        check("reset_volume", oVolume, 0);
        check("reset_len_nz", oLength_nonzero, 0);
        iReset = 1'b0;

        // Constant volume with the longest table entry.
        iEnable = 1'b1;
        tick();
        write_ctrl(8'h1F);
        write_length(8'h08);
        tick();
        check("const_volume", oVolume, 15);
        check("const_len_nz", oLength_nonzero, 1);

        // Decay mode, period 2: one decay step every 3 quarter-frames, holding at 0.
        write_ctrl(8'h02);
        write_length(8'h00);
        env_pulses(1);
        check("decay_start", oVolume, 15);
        for (int k = 14; k >= 0; k--) begin
            env_pulses(3);
            check("decay_step", oVolume, k);
        end
        env_pulses(6);
        check("decay_hold0", oVolume, 0);

        // Loop mode, period 0: wraps from 0 back to 15.
        write_ctrl(8'h20);
        write_length(8'h00);
        env_pulses(1);
        check("loop_start", oVolume, 15);
        env_pulses(15);
        check("loop_zero", oVolume, 0);
        env_pulses(1);
        check("loop_wrap", oVolume, 15);

        // Length counter expiry, then halt freezing it.
        write_ctrl(8'h00);
        write_length(8'h18);
        len_pulses(2);
        check("len_expire_nz", oLength_nonzero, 0);
        check("len_expire_vol", oVolume, 0);
        len_pulses(1);
        check("len_no_wrap", oLength_nonzero, 0);
        write_ctrl(8'h20);
        write_length(8'h18);
        len_pulses(2);
        check("len_halt_nz", oLength_nonzero, 1);

        // Channel disable clears the length and blocks loads.
        write_length(8'h00);
        iEnable = 1'b0;
        tick(); tick();
        check("disable_clear", oLength_nonzero, 0);
        write_length(8'h08);
        tick();
        check("disable_noload", oLength_nonzero, 0);
        iEnable = 1'b1;

        // Length write coinciding with a length clock at length 5.
        write_ctrl(8'h00);
        write_length(8'h38);
        len_pulses(1);
        iData = 8'h18; iWrite_length = 1'b1; iLength_clk = 1'b1;
        tick();
        iWrite_length = 1'b0; iLength_clk = 1'b0;
        len_pulses(2);
`ifdef LENGTH_RELOAD_GUARD_EN
        check("coincide_guard", oLength_nonzero, 1);
`else
        check("coincide_load", oLength_nonzero, 0);
`endif

        // Asynchronous reset mid-operation.
        write_ctrl(8'h1F);
        write_length(8'h08);
        tick();
        #1 iReset = 1'b1;
        #1;
        check("async_rst_vol", oVolume, 0);
        check("async_rst_nz", oLength_nonzero, 0);
        tick();
        iReset = 1'b0;
        env_pulses(1);
        check("post_rst_vol", oVolume, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            iData         = 8'($urandom);
            iWrite_ctrl   = ($urandom_range(0, 7) == 0);
            iWrite_length = ($urandom_range(0, 5) == 0);
            iEnable       = ($urandom_range(0, 15) != 0);
            iEnvelope_clk = ($urandom_range(0, 2) == 0);
            iLength_clk   = ($urandom_range(0, 4) == 0);
            tick();
        end
        iWrite_ctrl = 1'b0; iWrite_length = 1'b0; iEnvelope_clk = 1'b0; iLength_clk = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
